// File: rtl/counter_pkg.sv
// Shared constants and helpers for the updown_counter family.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 4;
  localparam int unsigned DEFAULT_PRESCALE_W = 4;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // Loaded values above the programmed top are pinned to the top.
  function automatic logic [31:0] clamp_to_max(input logic [31:0] val, input logic [31:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enabled-cycle prescaler: strikes once every presc+1 enabled cycles.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  restart,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] presc,
  output logic                  strike
);

  logic [PRESCALE_W-1:0] presc_q;

  // >= keeps the prescaler from running the long way round if presc shrinks mid-count.
  always_comb begin
    strike = en && (presc_q >= presc);
  end

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      presc_q <= '0;
    end else if (en) begin
      presc_q <= strike ? '0 : presc_q + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down modulo counter with load, clear, wrap/saturate and status flags.
// Optional prescaler enabled by defining UPDOWN_COUNTER_PRESCALE_EN.
module updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned MAX        = 2**WIDTH - 1,
  parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_en,
  input  logic                  io_up,
  input  logic                  io_sat,
  input  logic                  io_clear,
  input  logic                  io_load,
  input  logic [WIDTH-1:0]      io_load_val,
  input  logic                  io_ovf_clr,
`ifdef UPDOWN_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] io_presc,
`endif
  output logic [WIDTH-1:0]      io_out,
  output logic                  io_tc,
  output logic                  io_wrap,
  output logic                  io_ovf
);

  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             ovf_q;
  logic             step;
  logic [WIDTH:0]   count_x;
  logic             at_top;
  logic             at_bot;
  logic             ovf_set;
  logic [WIDTH-1:0] load_clamped;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .restart (io_clear | io_load),
    .en      (io_en),
    .presc   (io_presc),
    .strike  (step)
  );
`else
  // Without the prescaler every enabled cycle steps; the width is then irrelevant.
  always_comb begin
    step = io_en && (PRESCALE_W > 0);
  end
`endif

  always_comb begin
    count_x      = {1'b0, count_q};
    at_top       = (count_x >= MAX_X);
    at_bot       = (count_q == '0);
    load_clamped = WIDTH'(clamp_to_max(32'(io_load_val), 32'(MAX)));
    ovf_set      = step && !io_clear && !io_load && (io_sat == MODE_SAT) &&
                   ((io_up == DIR_UP) ? at_top : at_bot);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      ovf_q  <= ovf_set | (ovf_q & ~io_ovf_clr);
      if (io_clear) begin
        count_q <= '0;
      end else if (io_load) begin
        count_q <= load_clamped;
      end else if (step) begin
        if (io_up == DIR_UP) begin
          if (!at_top) begin
            count_q <= WIDTH'(count_x + (WIDTH+1)'(1));
          end else if (io_sat == MODE_WRAP) begin
            count_q <= '0;
            wrap_q  <= 1'b1;
          end
        end else begin
          if (!at_bot) begin
            count_q <= WIDTH'(count_x - (WIDTH+1)'(1));
          end else if (io_sat == MODE_WRAP) begin
            count_q <= MAX_W;
            wrap_q  <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    io_out  = count_q;
    io_wrap = wrap_q;
    io_ovf  = ovf_q;
    io_tc   = (io_up && (count_q == MAX_W)) || (!io_up && (count_q == '0));
  end

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: MAX=9 and MAX=15 instances share stimulus.
module tb_updown_counter;

  typedef struct {
    int out;
    bit wrap;
    bit ovf;
    int psc;
  } mstate_t;

  typedef struct {
    mstate_t a;
    mstate_t b;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       io_en, io_up, io_sat, io_clear, io_load, io_ovf_clr;
  logic [3:0] io_load_val;
  logic [3:0] io_presc;
  logic [3:0] out9, out15;
  logic       tc9, tc15, wrap9, wrap15, ovf9, ovf15;

  int n_checks = 0;
  int n_pass   = 0;
  mstate_t m9, m15;
  exp_t    exp_q[$];
  exp_t    e;

  updown_counter #(.WIDTH(4), .MAX(9), .PRESCALE_W(4)) dut9 (
    .clock(clock), .reset(reset), .io_en(io_en), .io_up(io_up), .io_sat(io_sat),
    .io_clear(io_clear), .io_load(io_load), .io_load_val(io_load_val),
    .io_ovf_clr(io_ovf_clr),
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    .io_presc(io_presc),
`endif
    .io_out(out9), .io_tc(tc9), .io_wrap(wrap9), .io_ovf(ovf9)
  );

  updown_counter #(.WIDTH(4), .MAX(15), .PRESCALE_W(4)) dut15 (
    .clock(clock), .reset(reset), .io_en(io_en), .io_up(io_up), .io_sat(io_sat),
    .io_clear(io_clear), .io_load(io_load), .io_load_val(io_load_val),
    .io_ovf_clr(io_ovf_clr),
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    .io_presc(io_presc),
`endif
    .io_out(out15), .io_tc(tc15), .io_wrap(wrap15), .io_ovf(ovf15)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic mstate_t model_next(input mstate_t s, input int max);
    mstate_t n;
    bit do_step;
    bit set_ovf;
    int presc_v;
    n = s;
    n.wrap = 0;
    set_ovf = 0;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    presc_v = int'(io_presc);
`else
    presc_v = 0;
`endif
    if (reset) begin
      n.out = 0; n.ovf = 0; n.psc = 0;
      return n;
    end
    do_step = 0;
    if (io_clear || io_load) n.psc = 0;
    else if (io_en) begin
      if (s.psc >= presc_v) begin do_step = 1; n.psc = 0; end
      else n.psc = s.psc + 1;
    end
    if (io_clear) n.out = 0;
    else if (io_load) n.out = (int'(io_load_val) > max) ? max : int'(io_load_val);
    else if (do_step) begin
      if (io_up) begin
        if (s.out < max) n.out = s.out + 1;
        else if (io_sat) set_ovf = 1;
        else begin n.out = 0; n.wrap = 1; end
      end else begin
        if (s.out > 0) n.out = s.out - 1;
        else if (io_sat) set_ovf = 1;
        else begin n.out = max; n.wrap = 1; end
      end
    end
    n.ovf = set_ovf || (s.ovf && !io_ovf_clr);
    return n;
  endfunction

  task automatic drive(input logic r, input logic en, input logic up, input logic sat,
                       input logic clr, input logic ld, input logic [3:0] lv, input logic oclr);
    @(negedge clock);
    reset = r; io_en = en; io_up = up; io_sat = sat;
    io_clear = clr; io_load = ld; io_load_val = lv; io_ovf_clr = oclr;
    m9  = model_next(m9, 9);
    m15 = model_next(m15, 15);
    exp_q.push_back('{a: m9, b: m15});
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 0, 0, 1, 4'd7, 0);
      e = exp_q.pop_front();
      n_checks++;
      if (out9 !== 4'(e.a.out) || wrap9 !== e.a.wrap || ovf9 !== e.a.ovf)
        $display("FAIL reset9: out=%0d wrap=%b ovf=%b, required out=%0d wrap=%b ovf=%b",
                 out9, wrap9, ovf9, e.a.out, e.a.wrap, e.a.ovf);
      else n_pass++;
      n_checks++;
      if (out15 !== 4'(e.b.out) || ovf15 !== e.b.ovf)
        $display("FAIL reset15: out=%0d ovf=%b, required out=%0d ovf=%b", out15, ovf15, e.b.out, e.b.ovf);
      else n_pass++;
    end
    n_checks++;
    if (tc9 !== 1'b0) $display("FAIL reset_tc_up: tc=%b required 0", tc9);
    else n_pass++;
  endtask

  task automatic test_up_wrap;
    for (int i = 1; i <= 10; i++) begin
      drive(0, 1, 1, 0, 0, 0, 4'd0, 0);
      e = exp_q.pop_front();
      n_checks++;
      if (out9 !== 4'(e.a.out) || wrap9 !== e.a.wrap)
        $display("FAIL up_wrap[%0d]: out=%0d wrap=%b, required out=%0d wrap=%b",
                 i, out9, wrap9, e.a.out, e.a.wrap);
      else n_pass++;
      n_checks++;
      if (tc9 !== (e.a.out == 9))
        $display("FAIL up_wrap_tc[%0d]: tc=%b required %b", i, tc9, e.a.out == 9);
      else n_pass++;
    end
  endtask

  task automatic test_down_sat;
    // load 2, four blocked-at-zero-capable steps, then ovf_clr with/without a blocked step
    drive(0, 0, 0, 1, 0, 1, 4'd2, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        e = exp_q.pop_front();
      end else if (i <= 4) begin
        drive(0, 1, 0, 1, 0, 0, 4'd0, 0);
        e = exp_q.pop_front();
      end else begin
        drive(0, 1, 0, 1, 0, 0, 4'd0, 1);
        e = exp_q.pop_front();
      end
      n_checks++;
      if (out9 !== 4'(e.a.out) || ovf9 !== e.a.ovf || wrap9 !== e.a.wrap)
        $display("FAIL down_sat[%0d]: out=%0d ovf=%b wrap=%b, required out=%0d ovf=%b wrap=%b",
                 i, out9, ovf9, wrap9, e.a.out, e.a.ovf, e.a.wrap);
      else n_pass++;
    end
    n_checks++;
    if (tc9 !== 1'b1) $display("FAIL down_sat_tc: tc=%b required 1", tc9);
    else n_pass++;
    drive(0, 0, 0, 1, 0, 0, 4'd0, 1);
    e = exp_q.pop_front();
    n_checks++;
    if (ovf9 !== e.a.ovf || ovf9 !== 1'b0)
      $display("FAIL ovf_clr_alone: ovf=%b required %b", ovf9, e.a.ovf);
    else n_pass++;
  endtask

  task automatic test_load_clamp;
    drive(0, 1, 1, 0, 0, 1, 4'd15, 0);
    e = exp_q.pop_front();
    n_checks++;
    if (out9 !== 4'(e.a.out) || out9 !== 4'd9)
      $display("FAIL load_clamp9: out=%0d required %0d", out9, e.a.out);
    else n_pass++;
    n_checks++;
    if (out15 !== 4'(e.b.out))
      $display("FAIL load_clamp15: out=%0d required %0d", out15, e.b.out);
    else n_pass++;
  endtask

  task automatic test_priority;
    drive(0, 0, 1, 1, 0, 1, 4'd5, 0);
    e = exp_q.pop_front();
    drive(0, 1, 1, 0, 1, 1, 4'd7, 0);
    e = exp_q.pop_front();
    n_checks++;
    if (out9 !== 4'(e.a.out) || ovf9 !== e.a.ovf || wrap9 !== e.a.wrap)
      $display("FAIL clear_priority: out=%0d ovf=%b wrap=%b, required out=%0d ovf=%b wrap=%b",
               out9, ovf9, wrap9, e.a.out, e.a.ovf, e.a.wrap);
    else n_pass++;
    drive(0, 1, 1, 0, 0, 1, 4'd8, 0);
    e = exp_q.pop_front();
    drive(1, 1, 1, 0, 0, 1, 4'd3, 0);
    e = exp_q.pop_front();
    n_checks++;
    if (out9 !== 4'(e.a.out) || ovf9 !== e.a.ovf)
      $display("FAIL reset_mid_count: out=%0d ovf=%b, required out=%0d ovf=%b", out9, ovf9, e.a.out, e.a.ovf);
    else n_pass++;
  endtask

  task automatic test_down_wrap15;
    drive(0, 0, 0, 0, 1, 0, 4'd0, 0);
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive(0, (i == 0), 0, 0, 0, 0, 4'd0, 0);
      e = exp_q.pop_front();
      n_checks++;
      if (out15 !== 4'(e.b.out) || wrap15 !== e.b.wrap)
        $display("FAIL down_wrap15[%0d]: out=%0d wrap=%b, required out=%0d wrap=%b",
                 i, out15, wrap15, e.b.out, e.b.wrap);
      else n_pass++;
      n_checks++;
      if (out9 !== 4'(e.a.out) || wrap9 !== e.a.wrap)
        $display("FAIL down_wrap9[%0d]: out=%0d wrap=%b, required out=%0d wrap=%b",
                 i, out9, wrap9, e.a.out, e.a.wrap);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 80; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0),
            4'($urandom), ($urandom_range(0, 5) == 0));
      e = exp_q.pop_front();
      n_checks++;
      if (out9 !== 4'(e.a.out) || wrap9 !== e.a.wrap || ovf9 !== e.a.ovf ||
          tc9 !== ((io_up && e.a.out == 9) || (!io_up && e.a.out == 0)))
        $display("FAIL random9[%0d]: out=%0d wrap=%b ovf=%b tc=%b, required out=%0d wrap=%b ovf=%b",
                 i, out9, wrap9, ovf9, tc9, e.a.out, e.a.wrap, e.a.ovf);
      else n_pass++;
      n_checks++;
      if (out15 !== 4'(e.b.out) || wrap15 !== e.b.wrap || ovf15 !== e.b.ovf ||
          tc15 !== ((io_up && e.b.out == 15) || (!io_up && e.b.out == 0)))
        $display("FAIL random15[%0d]: out=%0d wrap=%b ovf=%b tc=%b, required out=%0d wrap=%b ovf=%b",
                 i, out15, wrap15, ovf15, tc15, e.b.out, e.b.wrap, e.b.ovf);
      else n_pass++;
    end
  endtask

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  task automatic test_prescale;
    io_presc = 4'd2;
    drive(0, 0, 1, 0, 1, 0, 4'd0, 0);
    e = exp_q.pop_front();
    for (int i = 1; i <= 13; i++) begin
      drive(0, 1, 1, 0, 0, (i == 10), 4'd1, 0);
      e = exp_q.pop_front();
      n_checks++;
      if (out9 !== 4'(e.a.out) || (i <= 9 && out9 !== 4'(i / 3)))
        $display("FAIL prescale[%0d]: out=%0d required %0d", i, out9, e.a.out);
      else n_pass++;
    end
    io_presc = 4'd0;
  endtask
`endif

  initial begin
    reset = 1'b1; io_en = 0; io_up = 1; io_sat = 0; io_clear = 0; io_load = 0;
    io_load_val = '0; io_ovf_clr = 0; io_presc = '0;
    m9  = '{out: 0, wrap: 0, ovf: 0, psc: 0};
    m15 = '{out: 0, wrap: 0, ovf: 0, psc: 0};
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_load_clamp();
    test_priority();
    test_down_wrap15();
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    test_prescale();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
